// File: rtl/bitstream_decoder_if.sv
// Readout bundle between bitstream_decoder (master) and host-side consumer (slave).
// Carries density valid/ready handshake, sticky flags and the optional period result.
`timescale 1ns/1ps
interface bitstream_decoder_if #(
  parameter int WIN_LOG2  = 8,
  parameter int PER_WIDTH = 16
);
  logic [WIN_LOG2:0]    density;
  logic                 out_valid;
  logic                 out_ready;
  logic                 overrun;
  logic                 clr_ovr;
  logic [PER_WIDTH-1:0] period;
  logic                 period_valid;
  logic                 timeout;

  modport master (
    output density, out_valid, overrun, period, period_valid, timeout,
    input  out_ready, clr_ovr
  );

  modport slave (
    input  density, out_valid, overrun, period, period_valid, timeout,
    output out_ready, clr_ovr
  );
endinterface

// File: rtl/bitstream_decoder.sv
// Ones-density over 2^WIN_LOG2-cycle windows of a synchronized 1-bit stream; BITSTREAM_PERIOD_EN adds rising-edge period.
// Latency: bit_in to s_bit 2 clk; density/out_valid register on the edge that samples the last window index.
// Backpressure: none upstream; an unconsumed result is overwritten by the next one and overrun is flagged.
`timescale 1ns/1ps
module bitstream_decoder #(
  parameter int WIN_LOG2  = 8,
  parameter int PER_WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                bit_in,
  input  logic                en,
  bitstream_decoder_if.master rd
);
  localparam logic [WIN_LOG2-1:0] WIN_LAST = '1;
  localparam logic [WIN_LOG2-1:0] WIN_INC  = 1;

  logic                sync_q;
  logic                s_bit;
  logic [WIN_LOG2-1:0] win_cnt;
  logic [WIN_LOG2:0]   ones_cnt;
  logic [WIN_LOG2:0]   ones_next;
  logic                win_done;
  logic                take;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 1'b0;
      s_bit  <= 1'b0;
    end else begin
      sync_q <= bit_in;
      s_bit  <= sync_q;
    end
  end

  assign ones_next = ones_cnt + {{WIN_LOG2{1'b0}}, s_bit};
  assign win_done  = en && (win_cnt == WIN_LAST);
  assign take      = rd.out_valid && rd.out_ready;

  // Dropping en discards the partial window so the next enabled cycle is index 0.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      win_cnt  <= '0;
      ones_cnt <= '0;
    end else if (win_done) begin
      win_cnt  <= '0;
      ones_cnt <= '0;
    end else begin
      win_cnt  <= win_cnt + WIN_INC;
      ones_cnt <= ones_next;
    end
  end

  // A completing window beats a concurrent transfer: the fresh result keeps out_valid high.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd.density   <= '0;
      rd.out_valid <= 1'b0;
      rd.overrun   <= 1'b0;
    end else begin
      if (win_done) begin
        rd.density   <= ones_next;
        rd.out_valid <= 1'b1;
      end else if (take) begin
        rd.out_valid <= 1'b0;
      end

      if (win_done && rd.out_valid && !rd.out_ready) begin
        rd.overrun <= 1'b1;
      end else if (rd.clr_ovr) begin
        rd.overrun <= 1'b0;
      end
    end
  end

`ifdef BITSTREAM_PERIOD_EN
  localparam logic [PER_WIDTH-1:0] PER_MAX = '1;
  localparam logic [PER_WIDTH-1:0] PER_INC = 1;

  logic                 s_prev;
  logic                 armed;
  logic                 rise;
  logic [PER_WIDTH-1:0] per_cnt;

  assign rise = en && s_bit && !s_prev;

  // The first edge after reset or en rise only arms; later edges report edge-to-edge spacing.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_prev          <= 1'b0;
      armed           <= 1'b0;
      per_cnt         <= '0;
      rd.period       <= '0;
      rd.period_valid <= 1'b0;
      rd.timeout      <= 1'b0;
    end else begin
      s_prev          <= s_bit;
      rd.period_valid <= 1'b0;

      if (!en) begin
        armed   <= 1'b0;
        per_cnt <= '0;
      end else if (rise) begin
        armed   <= 1'b1;
        per_cnt <= '0;
        if (armed) begin
          rd.period       <= (per_cnt == PER_MAX) ? PER_MAX : per_cnt + PER_INC;
          rd.period_valid <= 1'b1;
        end
      end else if (per_cnt != PER_MAX) begin
        per_cnt <= per_cnt + PER_INC;
      end

      if (en && (per_cnt == PER_MAX)) begin
        rd.timeout <= 1'b1;
      end else if (rd.clr_ovr) begin
        rd.timeout <= 1'b0;
      end
    end
  end
`else
  assign rd.period       = {PER_WIDTH{1'b0}};
  assign rd.period_valid = 1'b0;
  assign rd.timeout      = 1'b0;
`endif

endmodule

// File: doc/bitstream_decoder.md
Name: bitstream_decoder

Overview:
Receive side for the single-bit accumulator-MSB stream produced by our accumulator/NCO blocks.
- Samples an asynchronous 1-bit stream.
- Counts the ones over a fixed window of 2^WIN_LOG2 cycles and delivers each density result through a valid/ready handshake.
- Optionally measures the rising-edge period.
- Sits between the pad input and the host-side readout logic.

Parameters:
WIN_LOG2, 8, log2 of window length in clk cycles (window = 256)
PER_WIDTH, 16, width of period counter/result (optional feature only)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
bit_in  input  1  asynchronous bitstream
en  input  1  measurement enable
density  output  WIN_LOG2+1  ones count of last completed window, range 0..2^WIN_LOG2
out_valid  output  1  density holds an unconsumed result
out_ready  input  1  consumer accepts density when out_valid && out_ready
overrun  output  1  sticky: a result was overwritten before being consumed
clr_ovr  input  1  clears overrun
period  output  PER_WIDTH  cycles between the last two rising edges
period_valid  output  1  one-cycle strobe when period updates
timeout  output  1  sticky: period counter saturated

Behaviour:
- Reset (rst=1 at a clk edge): all outputs 0; synchronizer, window counter, ones counter, period state cleared. Reset mid-window discards the partial window.
- Input path: bit_in passes through a 2-flop synchronizer; s_bit is the second flop. Latency bit_in→s_bit is 2 clk.
- Window: win_cnt (WIN_LOG2 bits) and ones_cnt (WIN_LOG2+1 bits) advance only while en=1.
  - Each enabled cycle samples s_bit at index win_cnt.
  - At index 2^WIN_LOG2-1: density <= ones_cnt + s_bit; ones_cnt <= 0; win_cnt wraps to 0.
  - At all other indices: ones_cnt += s_bit.
- Result timing: density/out_valid update on the clock edge after sampling index 2^WIN_LOG2-1 (out_valid seen 1 cycle after the last sample).
- en=0: win_cnt and ones_cnt cleared and held; the partial window is discarded. The next en=1 cycle is index 0. out_valid, density, overrun are unaffected.
- Handshake:
  - Transfer occurs when out_valid && out_ready.
  - out_valid clears on transfer unless a new result completes in the same cycle; then the new density loads, out_valid stays 1, no overrun.
  - New result while out_valid=1 && out_ready=0: density overwritten (newest wins), out_valid stays 1, overrun set.
  - density must stay stable while out_valid=1 and no new result arrives.
- overrun: set as above, cleared by clr_ovr. Set and clear in the same cycle: set wins.
- No arithmetic overflow is possible: density max 2^WIN_LOG2 fits WIN_LOG2+1 bits.

Optional Feature:
Macro: BITSTREAM_PERIOD_EN
- Defined:
  - Rising-edge detect on s_bit (previous s_bit=0, current=1), gated by en.
  - per_cnt counts enabled cycles since the last edge and saturates at 2^PER_WIDTH-1; reaching saturation sets timeout.
  - On an edge:
    - If an edge was already seen since reset/en rise: period <= per_cnt+1 and period_valid=1 for one cycle.
    - Otherwise arm only; no strobe.
    - Either way, per_cnt <= 0.
  - If saturated at the edge: period = 2^PER_WIDTH-1, timeout stays set.
  - timeout clears with clr_ovr; set wins on collision.
  - en=0 disarms the detector and clears per_cnt; period holds its value.
- Not defined: period, period_valid, timeout tied to 0; no period logic synthesized.

Test Plan:
- bit_in=1 constant, en=1, out_ready=1 → first density=256 with out_valid one cycle after the 256th enabled sample; repeats every 256 cycles; overrun=0.
- bit_in toggling each cycle → density=128 every window; with BITSTREAM_PERIOD_EN, period=2 strobing every 2 cycles after the first armed edge.
- bit_in pattern 1000 repeating → density=64; period=4; timeout=0.
- out_ready=0 across two window completions (bit_in=1) → density=256, out_valid=1, overrun=1; clr_ovr pulse → overrun=0. clr_ovr asserted on the completion cycle → overrun=1.
- Handshake/completion collision: out_valid=1 with out_ready=1 asserted exactly on the completion cycle → new density loaded, out_valid stays 1, overrun=0.
- rst asserted at window index 100 → all outputs 0 next cycle; then en=0 for 10 cycles and en=1 with bit_in=1 → first density=256 exactly 256 enabled cycles after en rise. PER_WIDTH=4 with bit_in held 0 for 20 cycles → timeout=1, no period_valid.
